bus_responder: RTL and testbench
================================

BUS_RESPONDER -- requirements
Module: bus_responder

Interface
REQ-001 The module SHALL have exactly one clock and an asynchronous, active-low reset; all state SHALL be updated on the rising edge of CLK only.
REQ-002 CLK  in  1  system clock.
REQ-003 nRESET  in  1  asynchronous active-low reset.
REQ-004 A  in  16  CPU address bus.
REQ-005 D_IN  in  8  CPU write data.
REQ-006 D_OUT  out  8  read data returned to the CPU.
REQ-007 D_OE  out  1  high while D_OUT must drive the data bus.
REQ-008 RD  in  1  CPU read strobe, active high.
REQ-009 WR  in  1  CPU write strobe, active high.
REQ-010 MMIO_REQ  out  1  address is in 0xFE00-0xFFFF.
REQ-011 IPL_REQ  out  1  address is in 0x0000-0x00FF and the boot ROM is still mapped.
REQ-012 PERIPH_IRQ  in  5  peripheral request lines, rising-edge significant. Bit order: 0 VBlank, 1 STAT, 2 Timer, 3 Serial, 4 Joypad.
REQ-013 CPU_IRQ_TRIG  out  8  pending interrupt flags presented to the CPU.
REQ-014 CPU_IRQ_ACK  in  8  per-bit interrupt acknowledge from the CPU, level, active high.
REQ-015 BOOT_OFF  out  1  sticky flag: the boot ROM is unmapped.

Function
REQ-016 MMIO_REQ SHALL be combinational and equal to 1 exactly when A[15:9] = 7'b1111111.
REQ-017 IPL_REQ SHALL be combinational and equal to 1 exactly when A[15:8] = 8'h00 and BOOT_OFF = 0.
REQ-018 The module SHALL hold a 5-bit interrupt flag register IF at address 0xFF0F and a 1-bit BOOT_OFF register at address 0xFF50.
REQ-019 A write strobe SHALL be the cycle in which WR = 1 and WR was 0 in the previous cycle; exactly one write SHALL commit per WR pulse, at the end of that cycle.
REQ-020 When a write strobe occurs with A = 0xFF0F, IF SHALL load D_IN[4:0]; D_IN[7:5] SHALL be ignored.
REQ-021 When a write strobe occurs with A = 0xFF50 and D_IN[0] = 1, BOOT_OFF SHALL be set to 1.
  - Once set, BOOT_OFF SHALL be cleared only by nRESET.
  - A write with D_IN[0] = 0 SHALL have no effect.
REQ-022 A peripheral set event SHALL be PERIPH_IRQ[i] = 1 in the current cycle while it was 0 in the previous cycle.
  - A line held high SHALL set IF[i] only once.
REQ-023 The next-state value of IF SHALL be computed as follows:
  - start from (write-strobe to 0xFF0F ? D_IN[4:0] : IF);
  - AND it with ~CPU_IRQ_ACK[4:0];
  - OR the result with the peripheral set events.
  - Consequence: a set event wins over both an acknowledge and a CPU write in the same cycle, so no request is lost.
REQ-024 CPU_IRQ_TRIG[4:0] SHALL equal IF (registered, no additional delay) and CPU_IRQ_TRIG[7:5] SHALL be 0.
  - Consequence: a set event is visible on CPU_IRQ_TRIG one clock after the edge is sampled.
REQ-025 CPU_IRQ_ACK[7:5] SHALL be ignored.
REQ-026 D_OE SHALL be combinational and equal to 1 exactly when RD = 1 and A is 0xFF0F or 0xFF50; reads SHALL have zero-cycle latency and SHALL have no side effects.
REQ-027 D_OUT SHALL be {3'b111, IF} for 0xFF0F, {7'b1111111, BOOT_OFF} for 0xFF50, and 8'hFF for any other address.
REQ-028 If RD and a write strobe occur together, the write SHALL still commit, and D_OUT SHALL show the pre-write value during that cycle.

Reset
REQ-029 While nRESET = 0, the module SHALL immediately (asynchronously) force:
  - IF = 0 and BOOT_OFF = 0;
  - CPU_IRQ_TRIG = 8'h00;
  - the previous-WR register and the previous-PERIPH_IRQ registers to all ones, so that lines held high across reset release produce no strobe or set event.
REQ-030 Assertion of nRESET during a WR pulse or an active interrupt SHALL abort it with no partial update; after release, normal operation SHALL resume on the next rising CLK edge.

Verification
REQ-031 Reset release with PERIPH_IRQ = 5'h1F held high -> IF stays 0 and CPU_IRQ_TRIG = 8'h00; lower then raise bit 2 -> CPU_IRQ_TRIG = 8'h04 one clock later.
REQ-032 Write 0xFF0F = 8'hE3 -> reading 0xFF0F returns 8'hE3, D_OE = 1, CPU_IRQ_TRIG = 8'h03; hold WR high for 4 cycles while PERIPH_IRQ[4] rises -> IF = 5'h13, with exactly one write committed.
REQ-033 IF = 5'h01, CPU_IRQ_ACK = 8'h01 and a PERIPH_IRQ[0] rising edge in the same cycle -> IF = 5'h01 afterwards; a later ACK alone -> IF = 5'h00.
REQ-034 A = 0x0042 -> IPL_REQ = 1, MMIO_REQ = 0; write 0xFF50 = 8'h01 -> BOOT_OFF = 1 and IPL_REQ = 0; write 0xFF50 = 8'h00 -> BOOT_OFF remains 1; read 0xFF50 -> 8'hFF.
REQ-035 A = 0xFE00 -> MMIO_REQ = 1; A = 0xFDFF -> MMIO_REQ = 0; RD at 0xC000 -> D_OE = 0.
REQ-036 Assert nRESET mid-WR pulse at 0xFF0F with IF = 5'h1F -> IF = 0 and BOOT_OFF = 0 immediately, with no write committed after release.

Source files
------------

// File: rtl/bus_responder_if.sv
// rtl/bus_responder_if.sv - CPU bus, interrupt and boot-ROM signals of the bus responder
interface bus_responder_if;
  logic [15:0] a;
  logic [7:0]  d_in;
  logic [7:0]  d_out;
  logic        d_oe;
  logic        rd;
  logic        wr;
  logic        mmio_req;
  logic        ipl_req;
  logic [4:0]  periph_irq;
  logic [7:0]  cpu_irq_trig;
  logic [7:0]  cpu_irq_ack;
  logic        boot_off;

  modport slave (
    input  a, d_in, rd, wr, periph_irq, cpu_irq_ack,
    output d_out, d_oe, mmio_req, ipl_req, cpu_irq_trig, boot_off
  );

  modport master (
    output a, d_in, rd, wr, periph_irq, cpu_irq_ack,
    input  d_out, d_oe, mmio_req, ipl_req, cpu_irq_trig, boot_off
  );
endinterface

// File: rtl/bus_responder.sv
// rtl/bus_responder.sv - address decode, IF register at 0xFF0F and sticky boot-ROM unmap at 0xFF50
module bus_responder (
  input logic            clk_i,
  input logic            rst_ni,
  bus_responder_if.slave bus
);
  logic [4:0] if_q, if_d;
  logic       boot_off_q, boot_off_d;
  logic       wr_prev_q;
  logic [4:0] irq_prev_q;

  logic       sel_if, sel_boot, wr_strobe;
  logic [4:0] irq_set, if_base;
  logic       unused_bits;

  always_comb begin
    sel_if    = (bus.a == 16'hFF0F);
    sel_boot  = (bus.a == 16'hFF50);
    wr_strobe = bus.wr & ~wr_prev_q;
    irq_set   = bus.periph_irq & ~irq_prev_q;
    // Set events are OR'd last so they beat both a CPU write and an acknowledge.
    if_base    = (wr_strobe && sel_if) ? bus.d_in[4:0] : if_q;
    if_d       = (if_base & ~bus.cpu_irq_ack[4:0]) | irq_set;
    boot_off_d = boot_off_q | (wr_strobe & sel_boot & bus.d_in[0]);
  end

  // Edge detectors reset high so lines already asserted at release stay silent.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      if_q       <= 5'h00;
      boot_off_q <= 1'b0;
      wr_prev_q  <= 1'b1;
      irq_prev_q <= 5'h1F;
    end else begin
      if_q       <= if_d;
      boot_off_q <= boot_off_d;
      wr_prev_q  <= bus.wr;
      irq_prev_q <= bus.periph_irq;
    end
  end

  always_comb begin
    bus.d_out = 8'hFF;
    if (sel_if)   bus.d_out = {3'b111, if_q};
    if (sel_boot) bus.d_out = {7'b1111111, boot_off_q};
  end

  assign bus.d_oe         = bus.rd & (sel_if | sel_boot);
  assign bus.mmio_req     = (bus.a[15:9] == 7'b1111111);
  assign bus.ipl_req      = (bus.a[15:8] == 8'h00) & ~boot_off_q;
  assign bus.cpu_irq_trig = {3'b000, if_q};
  assign bus.boot_off     = boot_off_q;
  assign unused_bits      = ^{bus.cpu_irq_ack[7:5], bus.d_in[7:5]};
endmodule

// File: tb/tb_bus_responder.sv
// tb/tb_bus_responder.sv - directed bench for bus_responder
module tb_bus_responder;
  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  bus_responder_if bus ();

  bus_responder dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [15:0] addr, input logic [7:0] data);
    bus.a    = addr;
    bus.d_in = data;
    bus.wr   = 1'b1;
    tick();
    bus.wr   = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    tick();
    n_total++; if (bus.cpu_irq_trig !== 8'h00) $display("FAIL reset_trig: got %h want 00", bus.cpu_irq_trig); else n_pass++;
    n_total++; if (bus.boot_off !== 1'b0) $display("FAIL reset_boot: got %b want 0", bus.boot_off); else n_pass++;
    rst_n = 1'b1;
    tick(); tick(); tick();
    n_total++; if (bus.cpu_irq_trig !== 8'h00) $display("FAIL release_held_irq: got %h want 00", bus.cpu_irq_trig); else n_pass++;
    bus.periph_irq = 5'h1B;
    tick();
    bus.periph_irq = 5'h1F;
    #2;
    n_total++; if (bus.cpu_irq_trig !== 8'h00) $display("FAIL irq_before_edge: got %h want 00", bus.cpu_irq_trig); else n_pass++;
    tick();
    n_total++; if (bus.cpu_irq_trig !== 8'h04) $display("FAIL irq_timer_rise: got %h want 04", bus.cpu_irq_trig); else n_pass++;
  endtask

  task automatic test_if_write();
    write_reg(16'hFF0F, 8'hE3);
    bus.a  = 16'hFF0F;
    bus.rd = 1'b1;
    #1;
    n_total++; if (bus.d_out !== 8'hE3) $display("FAIL if_read: got %h want E3", bus.d_out); else n_pass++;
    n_total++; if (bus.d_oe !== 1'b1) $display("FAIL if_oe: got %b want 1", bus.d_oe); else n_pass++;
    n_total++; if (bus.cpu_irq_trig !== 8'h03) $display("FAIL if_trig: got %h want 03", bus.cpu_irq_trig); else n_pass++;
    bus.rd = 1'b0;
    bus.periph_irq = 5'h0F;
    tick();
    bus.d_in = 8'hE3;
    bus.wr   = 1'b1;
    tick();
    bus.d_in = 8'h00;
    bus.periph_irq = 5'h1F;
    tick(); tick(); tick();
    n_total++; if (bus.cpu_irq_trig !== 8'h13) $display("FAIL wr_held_once: got %h want 13", bus.cpu_irq_trig); else n_pass++;
    bus.wr = 1'b0;
    tick();
    n_total++; if (bus.cpu_irq_trig !== 8'h13) $display("FAIL wr_release: got %h want 13", bus.cpu_irq_trig); else n_pass++;
  endtask

  task automatic test_ack();
    write_reg(16'hFF0F, 8'h01);
    bus.periph_irq = 5'h1E;
    tick();
    bus.cpu_irq_ack = 8'h01;
    bus.periph_irq  = 5'h1F;
    tick();
    bus.cpu_irq_ack = 8'h00;
    n_total++; if (bus.cpu_irq_trig !== 8'h01) $display("FAIL ack_vs_set: got %h want 01", bus.cpu_irq_trig); else n_pass++;
    bus.cpu_irq_ack = 8'hE0;
    tick();
    n_total++; if (bus.cpu_irq_trig !== 8'h01) $display("FAIL ack_upper_ignored: got %h want 01", bus.cpu_irq_trig); else n_pass++;
    bus.cpu_irq_ack = 8'h01;
    tick();
    bus.cpu_irq_ack = 8'h00;
    n_total++; if (bus.cpu_irq_trig !== 8'h00) $display("FAIL ack_clear: got %h want 00", bus.cpu_irq_trig); else n_pass++;
  endtask

  task automatic test_rd_wr_same();
    bus.a    = 16'hFF0F;
    bus.rd   = 1'b1;
    bus.d_in = 8'h05;
    bus.wr   = 1'b1;
    #1;
    n_total++; if (bus.d_out !== 8'hE0) $display("FAIL rdwr_prewrite: got %h want E0", bus.d_out); else n_pass++;
    tick();
    bus.wr = 1'b0;
    #1;
    n_total++; if (bus.d_out !== 8'hE5) $display("FAIL rdwr_commit: got %h want E5", bus.d_out); else n_pass++;
    bus.rd = 1'b0;
    tick();
  endtask

  task automatic test_boot();
    bus.a = 16'h0042;
    #1;
    n_total++; if (bus.ipl_req !== 1'b1) $display("FAIL ipl_mapped: got %b want 1", bus.ipl_req); else n_pass++;
    n_total++; if (bus.mmio_req !== 1'b0) $display("FAIL ipl_mmio: got %b want 0", bus.mmio_req); else n_pass++;
    bus.a = 16'hFF50;
    #1;
    n_total++; if (bus.d_out !== 8'hFE) $display("FAIL boot_read_pre: got %h want FE", bus.d_out); else n_pass++;
    write_reg(16'hFF50, 8'h01);
    bus.a = 16'h0042;
    #1;
    n_total++; if (bus.boot_off !== 1'b1) $display("FAIL boot_set: got %b want 1", bus.boot_off); else n_pass++;
    n_total++; if (bus.ipl_req !== 1'b0) $display("FAIL ipl_unmapped: got %b want 0", bus.ipl_req); else n_pass++;
    write_reg(16'hFF50, 8'h00);
    n_total++; if (bus.boot_off !== 1'b1) $display("FAIL boot_sticky: got %b want 1", bus.boot_off); else n_pass++;
    bus.a  = 16'hFF50;
    bus.rd = 1'b1;
    #1;
    n_total++; if (bus.d_out !== 8'hFF) $display("FAIL boot_read: got %h want FF", bus.d_out); else n_pass++;
    bus.rd = 1'b0;
  endtask

  task automatic test_decode();
    bus.a = 16'hFE00;
    #1;
    n_total++; if (bus.mmio_req !== 1'b1) $display("FAIL mmio_fe00: got %b want 1", bus.mmio_req); else n_pass++;
    bus.a = 16'hFDFF;
    #1;
    n_total++; if (bus.mmio_req !== 1'b0) $display("FAIL mmio_fdff: got %b want 0", bus.mmio_req); else n_pass++;
    bus.a  = 16'hC000;
    bus.rd = 1'b1;
    #1;
    n_total++; if (bus.d_oe !== 1'b0) $display("FAIL oe_c000: got %b want 0", bus.d_oe); else n_pass++;
    n_total++; if (bus.d_out !== 8'hFF) $display("FAIL dout_c000: got %h want FF", bus.d_out); else n_pass++;
    bus.rd = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_wr();
    write_reg(16'hFF0F, 8'h1F);
    n_total++; if (bus.cpu_irq_trig !== 8'h1F) $display("FAIL pre_reset_if: got %h want 1F", bus.cpu_irq_trig); else n_pass++;
    bus.a    = 16'hFF0F;
    bus.d_in = 8'h15;
    bus.wr   = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++; if (bus.cpu_irq_trig !== 8'h00) $display("FAIL async_reset_if: got %h want 00", bus.cpu_irq_trig); else n_pass++;
    n_total++; if (bus.boot_off !== 1'b0) $display("FAIL async_reset_boot: got %b want 0", bus.boot_off); else n_pass++;
    tick();
    rst_n = 1'b1;
    tick(); tick();
    n_total++; if (bus.cpu_irq_trig !== 8'h00) $display("FAIL no_write_after_release: got %h want 00", bus.cpu_irq_trig); else n_pass++;
    bus.wr = 1'b0;
    tick();
    n_total++; if (bus.cpu_irq_trig !== 8'h00) $display("FAIL post_release_idle: got %h want 00", bus.cpu_irq_trig); else n_pass++;
  endtask

  initial begin
    n_pass          = 0;
    n_total         = 0;
    rst_n           = 1'b0;
    bus.a           = 16'h0000;
    bus.d_in        = 8'h00;
    bus.rd          = 1'b0;
    bus.wr          = 1'b0;
    bus.periph_irq  = 5'h1F;
    bus.cpu_irq_ack = 8'h00;
    test_reset();
    test_if_write();
    test_ack();
    test_rd_wr_same();
    test_boot();
    test_decode();
    test_reset_mid_wr();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
